// File: rtl/test_probe_pkg.sv
// Shared types and config-field helpers for the probe test-access block.
package test_probe_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_RING   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  function automatic int unsigned cfg_width(int unsigned num_out, int unsigned sel_w);
    return num_out * sel_w + 2;
  endfunction

  function automatic int unsigned sel_lsb(int unsigned k, int unsigned sel_w);
    return k * sel_w;
  endfunction

  function automatic int unsigned mode_lsb(int unsigned cfg_w);
    return cfg_w - 2;
  endfunction

endpackage

// File: rtl/probe_capture_buf.sv
// Circular capture RAM with write/read pointers and fill count.
// A push into a full buffer overwrites the oldest entry and drags the read pointer along.
module probe_capture_buf #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full;

  assign full = (count_q == CNT_W'(DEPTH));

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clear_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        wr_d = wr_q + 1'b1;
      end
      if (pop_i || (push_i && full)) begin
        rd_d = rd_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = full ? count_q : count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/test_probe_ctrl.sv
// Probe observation mux with serial config chain and trigger-controlled capture buffer.
// Define PROBE_TIMESTAMP_EN to store a 16-bit cycle stamp per entry and expose outRdTs.
module test_probe_ctrl
  import test_probe_pkg::*;
#(
  parameter int unsigned NUM_PROBES = 8,
  parameter int unsigned PROBE_W    = 4,
  parameter int unsigned NUM_OUT    = 2,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned SEL_W      = $clog2(NUM_PROBES)
) (
  input  logic                          inClock,
  input  logic                          inReset,
  input  logic                          inCfgShiftEn,
  input  logic                          inCfgData,
  output logic                          outCfgData,
  input  logic                          inCfgUpdate,
  input  logic [NUM_PROBES*PROBE_W-1:0] inProbes,
  output logic [NUM_OUT*PROBE_W-1:0]    outObs,
  input  logic                          inTrigger,
  output logic                          outCapDone,
  input  logic                          inRdEn,
  output logic [NUM_OUT*PROBE_W-1:0]    outRdData,
  output logic                          outRdValid,
  output logic                          outEmpty
`ifdef PROBE_TIMESTAMP_EN
  ,
  output logic [15:0]                   outRdTs
`endif
);

  localparam int unsigned CFG_W = cfg_width(NUM_OUT, SEL_W);
  localparam int unsigned OBS_W = NUM_OUT * PROBE_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef PROBE_TIMESTAMP_EN
  localparam int unsigned BUF_W = OBS_W + 16;
`else
  localparam int unsigned BUF_W = OBS_W;
`endif

  logic [CFG_W-1:0] sreg_q, sreg_d, active_q, active_d;
  logic [OBS_W-1:0] sel_probes, obs_q, rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d, cap_done_q, cap_done_d, trig_q, trig_edge;
  state_e           state_q, state_d;
  mode_e            mode, new_mode;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d, cap_target, buf_count;
  logic             push, pop, clear, buf_empty;
  logic [BUF_W-1:0] buf_wdata, buf_rdata;

  // Config chain: shifting only touches sreg; update samples the pre-shift value.
  always_comb begin
    sreg_d   = sreg_q;
    active_d = active_q;
    if (inCfgShiftEn) begin
      sreg_d = {inCfgData, sreg_q[CFG_W-1:1]};
    end
    if (inCfgUpdate) begin
      active_d = sreg_q;
    end
  end

  // Out-of-range selects match no probe and leave the channel at zero.
  always_comb begin
    sel_probes = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      for (int unsigned p = 0; p < NUM_PROBES; p++) begin
        if (active_q[sel_lsb(k, SEL_W) +: SEL_W] == SEL_W'(p)) begin
          sel_probes[k*PROBE_W +: PROBE_W] = inProbes[p*PROBE_W +: PROBE_W];
        end
      end
    end
  end

  assign mode       = mode_e'(active_q[mode_lsb(CFG_W) +: 2]);
  assign new_mode   = mode_e'(sreg_q[mode_lsb(CFG_W) +: 2]);
  assign trig_edge  = inTrigger & ~trig_q;
  assign cap_target = (mode == MODE_RING) ? CNT_W'(DEPTH / 2) : CNT_W'(DEPTH);

  always_comb begin
    state_d   = state_q;
    cap_cnt_d = cap_cnt_q;
    push      = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    if (inCfgUpdate) begin
      clear     = 1'b1;
      cap_cnt_d = '0;
      state_d   = (new_mode inside {MODE_SINGLE, MODE_RING}) ? StArmed : StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StArmed: begin
          push = trig_edge || (mode == MODE_RING);
          if (trig_edge) begin
            cap_cnt_d = CNT_W'(1);
            state_d   = StCapture;
          end
        end
        StCapture: begin
          push      = 1'b1;
          cap_cnt_d = cap_cnt_q + 1'b1;
          if (cap_cnt_d == cap_target) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (inRdEn && !buf_empty) begin
            pop = 1'b1;
            if (buf_count == CNT_W'(1)) begin
              state_d = StIdle;
            end
          end
        end
      endcase
    end
  end

  // Done stays high for the cycle carrying the final read data.
  assign cap_done_d = !inCfgUpdate && (state_d == StDone || state_q == StDone);
  assign rd_valid_d = pop;
  assign rd_data_d  = pop ? buf_rdata[OBS_W-1:0] : rd_data_q;

  always_ff @(posedge inClock) begin
    if (!inReset) begin
      sreg_q     <= '0;
      active_q   <= '0;
      obs_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cap_done_q <= 1'b0;
      trig_q     <= 1'b0;
      cap_cnt_q  <= '0;
      state_q    <= StIdle;
    end else begin
      sreg_q     <= sreg_d;
      active_q   <= active_d;
      obs_q      <= sel_probes;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cap_done_q <= cap_done_d;
      trig_q     <= inTrigger;
      cap_cnt_q  <= cap_cnt_d;
      state_q    <= state_d;
    end
  end

`ifdef PROBE_TIMESTAMP_EN
  logic [15:0] ts_q, rd_ts_q;

  assign buf_wdata = {ts_q, sel_probes};

  always_ff @(posedge inClock) begin
    if (!inReset) begin
      ts_q    <= '0;
      rd_ts_q <= '0;
    end else begin
      ts_q    <= ts_q + 16'd1;
      rd_ts_q <= pop ? buf_rdata[BUF_W-1 -: 16] : rd_ts_q;
    end
  end

  assign outRdTs = rd_ts_q;
`else
  assign buf_wdata = sel_probes;
`endif

  probe_capture_buf #(
    .DEPTH  (DEPTH),
    .DATA_W (BUF_W)
  ) u_buf (
    .clk_i   (inClock),
    .rst_ni  (inReset),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (buf_wdata),
    .rdata_o (buf_rdata),
    .count_o (buf_count),
    .empty_o (buf_empty)
  );

  assign outCfgData = sreg_q[0];
  assign outObs     = obs_q;
  assign outRdData  = rd_data_q;
  assign outRdValid = rd_valid_q;
  assign outCapDone = cap_done_q;
  assign outEmpty   = buf_empty;

endmodule

// File: tb/tb_test_probe_ctrl.sv
// Directed bench for test_probe_ctrl (8 probes x 4 bits, 2 channels, 16-entry buffer).
module tb_test_probe_ctrl;

  logic        clk = 1'b0;
  logic        inReset, inCfgShiftEn, inCfgData, inCfgUpdate, inTrigger, inRdEn;
  logic [31:0] inProbes;
  logic        outCfgData, outCapDone, outRdValid, outEmpty;
  logic [7:0]  outObs, outRdData;
`ifdef PROBE_TIMESTAMP_EN
  logic [15:0] outRdTs;
  logic [15:0] prev_ts, exp_ts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  test_probe_ctrl dut (
    .inClock      (clk),
    .inReset      (inReset),
    .inCfgShiftEn (inCfgShiftEn),
    .inCfgData    (inCfgData),
    .outCfgData   (outCfgData),
    .inCfgUpdate  (inCfgUpdate),
    .inProbes     (inProbes),
    .outObs       (outObs),
    .inTrigger    (inTrigger),
    .outCapDone   (outCapDone),
    .inRdEn       (inRdEn),
    .outRdData    (outRdData),
    .outRdValid   (outRdValid),
    .outEmpty     (outEmpty)
`ifdef PROBE_TIMESTAMP_EN
    ,
    .outRdTs      (outRdTs)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_cfg(input logic [7:0] pat);
    for (int i = 0; i < 8; i++) begin
      inCfgShiftEn = 1'b1;
      inCfgData    = pat[i];
      step();
    end
    inCfgShiftEn = 1'b0;
    inCfgData    = 1'b0;
  endtask

  task automatic update();
    inCfgUpdate = 1'b1;
    step();
    inCfgUpdate = 1'b0;
  endtask

  // Ramp: probe p carries v+p-2, so probe2 = v and probe3 = v+1.
  function automatic logic [31:0] mk(input int v);
    logic [31:0] r;
    r = '0;
    for (int p = 0; p < 8; p++) r[p*4 +: 4] = 4'(v + p + 14);
    return r;
  endfunction

  function automatic logic [7:0] exp_rd(input int v);
    logic [3:0] lo, hi;
    lo = 4'(v);
    hi = 4'(v + 1);
    return {hi, lo};
  endfunction

  initial begin
    inReset = 1'b0; inCfgShiftEn = 1'b0; inCfgData = 1'b0; inCfgUpdate = 1'b0;
    inTrigger = 1'b0; inRdEn = 1'b0; inProbes = 32'h8765_4321;
    step();
    step();
    check("rst_obs", outObs, 8'h00);
    check("rst_capdone", outCapDone, 1'b0);
    check("rst_rdvalid", outRdValid, 1'b0);
    check("rst_rddata", outRdData, 8'h00);
    check("rst_empty", outEmpty, 1'b1);
    check("rst_cfgout", outCfgData, 1'b0);

    inReset = 1'b1;
    step();
    check("obs_default", outObs, 8'h11);

    // SINGLE, ch1=3, ch0=2
    shift_cfg(8'b01_011_010);
    check("obs_shift_no_effect", outObs, 8'h11);
    update();
    step();
    check("obs_cfg", outObs, 8'h43);
    check("armed_capdone", outCapDone, 1'b0);

    inCfgShiftEn = 1'b1; inCfgData = 1'b0;
    step();
    inCfgShiftEn = 1'b0;
    check("cfg_chain_out", outCfgData, 1'b1);
    check("obs_after_extra_shift", outObs, 8'h43);

    inRdEn = 1'b1;
    step();
    inRdEn = 1'b0;
    check("rd_armed_novalid", outRdValid, 1'b0);
    check("rd_armed_empty", outEmpty, 1'b1);

    // SINGLE capture with edge at ramp value 5
    for (int v = 0; v <= 21; v++) begin
      inProbes  = mk(v);
      inTrigger = (v >= 5);
      step();
    end
    inTrigger = 1'b0;
    check("single_done", outCapDone, 1'b1);
    check("single_not_empty", outEmpty, 1'b0);
    check("obs_ramp", outObs, exp_rd(21));

    for (int i = 0; i < 16; i++) begin
      inRdEn = 1'b1;
      step();
      check("single_rdvalid", outRdValid, 1'b1);
      check("single_rddata", outRdData, exp_rd(5 + i));
`ifdef PROBE_TIMESTAMP_EN
      if (i > 0) begin
        exp_ts = prev_ts + 16'd1;
        check("single_ts_step", outRdTs, exp_ts);
      end
      prev_ts = outRdTs;
`endif
    end
    check("single_done_last", outCapDone, 1'b1);
    inRdEn = 1'b0;
    step();
    check("single_done_fall", outCapDone, 1'b0);
    check("single_valid_end", outRdValid, 1'b0);
    check("single_empty_end", outEmpty, 1'b1);

    inRdEn = 1'b1;
    step();
    inRdEn = 1'b0;
    check("rd_empty_novalid", outRdValid, 1'b0);

    // Reset mid-shift
    inProbes = 32'h8765_4321;
    for (int i = 0; i < 4; i++) begin
      inCfgShiftEn = 1'b1;
      inCfgData    = i[0];
      step();
    end
    inCfgShiftEn = 1'b0;
    inReset = 1'b0;
    step();
    check("midshift_rst_obs", outObs, 8'h00);
    inReset = 1'b1;
    step();
    check("midshift_obs", outObs, 8'h11);
    inTrigger = 1'b1;
    step();
    step();
    inTrigger = 1'b0;
    check("midshift_idle_empty", outEmpty, 1'b1);
    check("midshift_idle_done", outCapDone, 1'b0);

    // Mode OFF, ch1=0, ch0=7
    shift_cfg(8'b00_000_111);
    update();
    step();
    check("obs_off_cfg", outObs, 8'h18);
    inTrigger = 1'b1;
    step();
    step();
    inTrigger = 1'b0;
    check("off_no_capture", outEmpty, 1'b1);

    // RING, edge after 40 writes
    shift_cfg(8'b10_011_010);
    update();
    for (int v = 0; v < 40; v++) begin
      inProbes = mk(v);
      inRdEn   = (v == 20);
      step();
      if (v == 20) check("ring_rd_armed_novalid", outRdValid, 1'b0);
      if (v == 10) check("ring_armed_filling", outEmpty, 1'b0);
    end
    inRdEn = 1'b0;
    for (int v = 40; v < 48; v++) begin
      inProbes  = mk(v);
      inTrigger = 1'b1;
      step();
    end
    inTrigger = 1'b0;
    check("ring_done", outCapDone, 1'b1);
    for (int i = 0; i < 16; i++) begin
      inRdEn = 1'b1;
      step();
      check("ring_rdvalid", outRdValid, 1'b1);
      check("ring_rddata", outRdData, exp_rd(32 + i));
    end
    inRdEn = 1'b0;
    step();
    check("ring_done_fall", outCapDone, 1'b0);
    check("ring_empty_end", outEmpty, 1'b1);

    // Update coinciding with a trigger edge in ARMED
    shift_cfg(8'b01_011_010);
    update();
    step();
    inTrigger   = 1'b1;
    inCfgUpdate = 1'b1;
    step();
    inCfgUpdate = 1'b0;
    check("upd_wins_empty", outEmpty, 1'b1);
    check("upd_wins_done", outCapDone, 1'b0);
    step();
    step();
    step();
    check("upd_wins_still_empty", outEmpty, 1'b1);
    inTrigger = 1'b0;
    step();
    inTrigger = 1'b1;
    step();
    check("rearmed_captures", outEmpty, 1'b0);
    inTrigger = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
